// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and types for the programmable clock divider.
//   CNT_W_DEF     : default counter / divisor width in bits
//   DIV_RESET_DEF : divisor loaded into every channel at reset
//   MIN_DIV       : smallest effective divisor (0 and 1 behave as this)
//   ch_state_e    : per-channel run state
// No ports (package).
// ---------------------------------------------------------------------------
package clk_div_pkg;

    localparam int          CNT_W_DEF     = 27;
    localparam int unsigned DIV_RESET_DEF = 100000000;
    localparam int          MIN_DIV       = 2;

    // IDLE: disabled, outputs held low.
    // ARM : enable seen once; the first period starts on the next edge.
    // RUN : counting 0..E-1.
    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_ARM  = 2'd1,
        CH_RUN  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/clk_div_channel.sv
// ---------------------------------------------------------------------------
// clk_div_channel
// One independent divider channel: counter, active/pending divisor and
// registered clk_out / tick generation.
// Optional feature macro: PROG_CLK_DIV_DUTY_EN (adds duty_value_i, a
// programmable high-phase length loaded alongside the divisor).
// Ports:
//   clk_in        : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   en_i          : run enable
//   load_i        : single-cycle divisor load strobe
//   div_value_i   : divisor captured on load_i
//   duty_value_i  : high-phase length captured on load_i (macro only)
//   pending_o     : a loaded divisor is waiting to be applied
//   clk_out_o     : registered divided clock
//   tick_o        : one-cycle pulse with each clk_out_o rising edge
// ---------------------------------------------------------------------------
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int          CNT_W     = CNT_W_DEF,
    parameter int unsigned DIV_RESET = DIV_RESET_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_value_i,
`ifdef PROG_CLK_DIV_DUTY_EN
    input  logic [CNT_W-1:0] duty_value_i,
`endif
    output logic             pending_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] DIV_RESET_V = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] MIN_DIV_V   = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] ONE_V       = CNT_W'(1);

    ch_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pendDiv_q;
    logic             pend_q;
    logic             clk_q;
    logic             tick_q;
`ifdef PROG_CLK_DIV_DUTY_EN
    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] pendDuty_q;
`endif

    logic [CNT_W-1:0] effDiv_d;
    logic [CNT_W-1:0] lastCnt_d;
    logic [CNT_W-1:0] highLen_d;
    logic [CNT_W-1:0] cntInc_d;
    logic             wrap_d;
    logic             apply_d;

    // Effective divisor, high-phase length and period boundary for the
    // period currently being generated. highLen_d is always >= 1, so the
    // first cycle of every period is high.
    always_comb begin
        effDiv_d  = (div_q < MIN_DIV_V) ? MIN_DIV_V : div_q;
        lastCnt_d = effDiv_d - ONE_V;
`ifdef PROG_CLK_DIV_DUTY_EN
        highLen_d = (duty_q == '0) ? ONE_V : duty_q;
        if (highLen_d > lastCnt_d) begin
            highLen_d = lastCnt_d;
        end
`else
        // Odd divisors give the extra cycle to the high phase.
        highLen_d = effDiv_d - (effDiv_d >> 1);
`endif
        cntInc_d  = cnt_q + ONE_V;
        wrap_d    = (cnt_q >= lastCnt_d);
        // A pending divisor is only applied at a period boundary while
        // running; any non-running edge is safe to apply on.
        apply_d   = pend_q && (!en_i || (state_q != CH_RUN) || wrap_d);
    end

    // Channel state machine, divisor bookkeeping and registered outputs.
    // The apply uses the old pending value, so a load landing on the wrap
    // edge is held for the following wrap.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CH_IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_RESET_V;
            pendDiv_q  <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
`ifdef PROG_CLK_DIV_DUTY_EN
            duty_q     <= '0;
            pendDuty_q <= '0;
`endif
        end else begin
            if (apply_d) begin
                div_q  <= pendDiv_q;
`ifdef PROG_CLK_DIV_DUTY_EN
                duty_q <= pendDuty_q;
`endif
            end

            if (load_i) begin
                pendDiv_q  <= div_value_i;
`ifdef PROG_CLK_DIV_DUTY_EN
                pendDuty_q <= duty_value_i;
`endif
                pend_q     <= 1'b1;
            end else if (apply_d) begin
                pend_q     <= 1'b0;
            end

            tick_q <= 1'b0;
            if (!en_i) begin
                state_q <= CH_IDLE;
                cnt_q   <= '0;
                clk_q   <= 1'b0;
            end else begin
                case (state_q)
                    CH_IDLE: begin
                        state_q <= CH_ARM;
                        cnt_q   <= '0;
                        clk_q   <= 1'b0;
                    end
                    CH_ARM: begin
                        state_q <= CH_RUN;
                        cnt_q   <= '0;
                        clk_q   <= 1'b1;
                        tick_q  <= 1'b1;
                    end
                    CH_RUN: begin
                        if (wrap_d) begin
                            cnt_q  <= '0;
                            clk_q  <= 1'b1;
                            tick_q <= 1'b1;
                        end else begin
                            cnt_q  <= cntInc_d;
                            clk_q  <= (cntInc_d < highLen_d);
                        end
                    end
                    default: begin
                        state_q <= CH_IDLE;
                        cnt_q   <= '0;
                        clk_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pending_o = pend_q;
    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/prog_clk_divider.sv
// ---------------------------------------------------------------------------
// prog_clk_divider
// NCH independent programmable clock dividers on a single system clock.
// The top only slices the per-channel buses; all logic is in
// clk_div_channel.
// Optional feature macro: PROG_CLK_DIV_DUTY_EN (adds port duty_value).
// Ports:
//   clk_in      : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   en          : per-channel run enable                   [NCH]
//   div_load    : per-channel divisor load strobe          [NCH]
//   div_value   : per-channel divisor, ch k at [k*CNT_W +: CNT_W]
//   duty_value  : per-channel high-phase length (macro only), same layout
//   div_pending : per-channel loaded divisor not yet applied [NCH]
//   clk_out     : per-channel registered divided clock     [NCH]
//   tick        : per-channel pulse on clk_out rising edge [NCH]
// ---------------------------------------------------------------------------
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          CNT_W     = CNT_W_DEF,
    parameter int unsigned DIV_RESET = DIV_RESET_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       div_load,
    input  logic [NCH*CNT_W-1:0] div_value,
`ifdef PROG_CLK_DIV_DUTY_EN
    input  logic [NCH*CNT_W-1:0] duty_value,
`endif
    output logic [NCH-1:0]       div_pending,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        clk_div_channel #(
            .CNT_W     (CNT_W),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk_in       (clk_in),
            .rst_n        (rst_n),
            .en_i         (en[k]),
            .load_i       (div_load[k]),
            .div_value_i  (div_value[k*CNT_W +: CNT_W]),
`ifdef PROG_CLK_DIV_DUTY_EN
            .duty_value_i (duty_value[k*CNT_W +: CNT_W]),
`endif
            .pending_o    (div_pending[k]),
            .clk_out_o    (clk_out[k]),
            .tick_o       (tick[k])
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// ---------------------------------------------------------------------------
// tb_prog_clk_divider
// Directed testbench for prog_clk_divider (NCH=4, CNT_W=8, DIV_RESET=4).
// Expected clk_out / tick / div_pending vectors are queued as stimulus is
// applied and compared one entry per clock after each rising edge.
// ---------------------------------------------------------------------------
module tb_prog_clk_divider;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    typedef struct {
        logic [NCH-1:0] clk;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] pend;
    } exp_t;

    logic                 clk_in;
    logic                 rst_n;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       div_load;
    logic [NCH*CNT_W-1:0] div_value;
`ifdef PROG_CLK_DIV_DUTY_EN
    logic [NCH*CNT_W-1:0] duty_value;
`endif
    logic [NCH-1:0]       div_pending;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;

    exp_t  sbQ[$];
    int    checkCount;
    int    passCount;
    string phaseTag;

    prog_clk_divider #(
        .NCH       (NCH),
        .CNT_W     (CNT_W),
        .DIV_RESET (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .en          (en),
        .div_load    (div_load),
        .div_value   (div_value),
`ifdef PROG_CLK_DIV_DUTY_EN
        .duty_value  (duty_value),
`endif
        .div_pending (div_pending),
        .clk_out     (clk_out),
        .tick        (tick)
    );

    // Free-running system clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference high-phase length for an effective divisor e.
    function automatic int highOf(input int e);
`ifdef PROG_CLK_DIV_DUTY_EN
        return 1;
`else
        return e - (e / 2);
`endif
    endfunction

    // One comparison; counts and reports.
    task automatic checkOutput(input string tag, input logic [NCH-1:0] got,
                               input logic [NCH-1:0] want);
        checkCount++;
        assert (got === want) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    // Drive enable, load strobes and one channel's divisor slice.
    task automatic applyStimulus(input logic [NCH-1:0] enV,
                                 input logic [NCH-1:0] loadV,
                                 input int ch, input int val);
        en       = enV;
        div_load = loadV;
        div_value[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    // Queue an all-low output entry with the given pending vector.
    task automatic pushZero(input logic [NCH-1:0] pendV);
        exp_t e;
        e.clk  = '0;
        e.tick = '0;
        e.pend = pendV;
        sbQ.push_back(e);
    endtask

    // Queue n cycles of a running channel with effective divisor e,
    // starting at period position startK.
    task automatic pushSeq(input int ch, input int e, input int startK,
                           input int n, input logic pendBit);
        exp_t x;
        int   pos;
        for (int j = 0; j < n; j++) begin
            pos = (startK + j) % e;
            x.clk  = '0;
            x.tick = '0;
            x.pend = '0;
            x.clk[ch]  = (pos < highOf(e));
            x.tick[ch] = (pos == 0);
            x.pend[ch] = pendBit;
            sbQ.push_back(x);
        end
    endtask

    // Compare one queued entry after every rising edge until empty.
    task automatic drain();
        exp_t e;
        while (sbQ.size() > 0) begin
            @(posedge clk_in);
            #1;
            e = sbQ.pop_front();
            checkOutput({phaseTag, " clk_out"}, clk_out, e.clk);
            checkOutput({phaseTag, " tick"}, tick, e.tick);
            checkOutput({phaseTag, " div_pending"}, div_pending, e.pend);
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b0;
        en         = '0;
        div_load   = '0;
        div_value  = '0;
`ifdef PROG_CLK_DIV_DUTY_EN
        duty_value = '0;
`endif

        // Reset state, no edge needed.
        phaseTag = "reset";
        #3;
        checkOutput("reset clk_out", clk_out, '0);
        checkOutput("reset tick", tick, '0);
        checkOutput("reset div_pending", div_pending, '0);
        @(negedge clk_in);
        rst_n = 1'b1;
        pushZero('0);
        drain();

        // Channel 0 at the reset divisor: 1100 repeating.
        phaseTag = "ch0_div4";
        applyStimulus(4'b0001, 4'b0000, 0, 0);
        pushZero('0);
        pushSeq(0, 4, 0, 12, 1'b0);
        drain();

        // Switch to channel 1, then load 5 mid-period.
        phaseTag = "ch1_load5";
        applyStimulus(4'b0010, 4'b0000, 1, 0);
        pushZero('0);
        pushSeq(1, 4, 0, 6, 1'b0);
        drain();
        applyStimulus(4'b0010, 4'b0010, 1, 5);
        pushSeq(1, 4, 6, 1, 1'b1);
        drain();
        applyStimulus(4'b0010, 4'b0000, 1, 5);
        pushSeq(1, 4, 7, 1, 1'b1);
        pushSeq(1, 5, 0, 10, 1'b0);
        drain();

        // D=0 loaded on the wrap edge: held for one more period.
        phaseTag = "ch1_load0";
        applyStimulus(4'b0010, 4'b0010, 1, 0);
        pushSeq(1, 5, 0, 1, 1'b1);
        drain();
        applyStimulus(4'b0010, 4'b0000, 1, 0);
        pushSeq(1, 5, 1, 4, 1'b1);
        pushSeq(1, 2, 0, 6, 1'b0);
        drain();

        // D=1 also behaves as 2.
        phaseTag = "ch1_load1";
        applyStimulus(4'b0010, 4'b0010, 1, 1);
        pushSeq(1, 2, 0, 1, 1'b1);
        drain();
        applyStimulus(4'b0010, 4'b0000, 1, 1);
        pushSeq(1, 2, 1, 1, 1'b1);
        pushSeq(1, 2, 0, 4, 1'b0);
        drain();

        // 6 then 8 before the wrap: only 8 takes effect.
        phaseTag = "ch1_last_wins";
        applyStimulus(4'b0010, 4'b0010, 1, 6);
        pushSeq(1, 2, 0, 1, 1'b1);
        drain();
        applyStimulus(4'b0010, 4'b0010, 1, 8);
        pushSeq(1, 2, 1, 1, 1'b1);
        drain();
        applyStimulus(4'b0010, 4'b0000, 1, 8);
        pushSeq(1, 8, 0, 16, 1'b0);
        drain();

        // Drop enable in the high phase, load while disabled, re-enable.
        phaseTag = "ch1_disable";
        pushSeq(1, 8, 0, 2, 1'b0);
        drain();
        applyStimulus(4'b0000, 4'b0000, 1, 8);
        pushZero('0);
        drain();
        applyStimulus(4'b0000, 4'b0010, 1, 3);
        pushZero(4'b0010);
        drain();
        applyStimulus(4'b0000, 4'b0000, 1, 3);
        pushZero('0);
        drain();
        phaseTag = "ch1_reenable";
        applyStimulus(4'b0010, 4'b0000, 1, 3);
        pushZero('0);
        pushSeq(1, 3, 0, 6, 1'b0);
        drain();

        // Leave a divisor pending, then reset asynchronously mid-period.
        phaseTag = "async_reset";
        applyStimulus(4'b0010, 4'b0010, 1, 7);
        pushSeq(1, 3, 0, 1, 1'b1);
        drain();
        applyStimulus(4'b0010, 4'b0000, 1, 7);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset clk_out", clk_out, '0);
        checkOutput("async_reset tick", tick, '0);
        checkOutput("async_reset div_pending", div_pending, '0);
        @(negedge clk_in);
        rst_n = 1'b1;

        // Restart from reset uses DIV_RESET again, not 3 or 7.
        phaseTag = "post_reset";
        pushZero('0);
        pushSeq(1, 4, 0, 8, 1'b0);
        drain();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
